// File: rtl/fruta_if.sv
`default_nettype none
// ============================================================================
// Module   : fruta_if
// Purpose  : Bundles the fruit-placement request/result handshake and the
//            shared map-memory read port into one interface.
// Ports    : fruta_enable   request pulse (requester -> engine)
//            fruta_wenable  result strobe, fruta_wx/fruta_wy/fruta_full valid
//            fruta_renable  map read strobe, address fruta_rx/fruta_ry
//            fruta_rdata    map cell, valid the cycle after fruta_renable
//            busy           engine is not idle
// Modports : slave  - the placement engine (fruta_gen)
//            master - the surroundings (update FSM plus map memory)
// Revision : 1.0 - initial release
// ============================================================================
interface fruta_if;
  logic       fruta_enable;
  logic       fruta_wenable;
  logic [9:0] fruta_wx;
  logic [9:0] fruta_wy;
  logic       fruta_full;
  logic       fruta_renable;
  logic [9:0] fruta_rx;
  logic [9:0] fruta_ry;
  logic [1:0] fruta_rdata;
  logic       busy;

  modport slave (
    input  fruta_enable, fruta_rdata,
    output fruta_wenable, fruta_wx, fruta_wy, fruta_full,
           fruta_renable, fruta_rx, fruta_ry, busy
  );

  modport master (
    output fruta_enable, fruta_rdata,
    input  fruta_wenable, fruta_wx, fruta_wy, fruta_full,
           fruta_renable, fruta_rx, fruta_ry, busy
  );
endinterface
`default_nettype wire

// File: rtl/fruta_gen.sv
`default_nettype none
// ============================================================================
// Module   : fruta_gen
// Purpose  : Fruit placement engine. On a request it draws pseudo-random
//            cells from a free-running 16-bit Galois LFSR, reads each
//            candidate from the map memory and returns the first empty cell.
// Ports    : clk    system clock
//            reset  synchronous reset, active-high
//            bus    fruta_if.slave (request/result strobes, map read port,
//                   busy)
// Options  : FRUTA_SCAN_FALLBACK_EN - when defined, after MAX_TRIES occupied
//            candidates the map is scanned row-major, and a full map is
//            reported through fruta_full. When undefined, occupied
//            candidates are redrawn forever and fruta_full is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module fruta_gen #(
  parameter int          MAPA_WIDTH  = 40,
  parameter int          MAPA_HEIGHT = 30,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          MAX_TRIES   = 64
) (
  input  logic   clk,
  input  logic   reset,
  fruta_if.slave bus
);
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [9:0]  X_LAST    = 10'(MAPA_WIDTH - 1);
  localparam logic [9:0]  Y_LAST    = 10'(MAPA_HEIGHT - 1);

  // READ is the cycle the map read strobe is high; CHECK samples the data.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DRAW       = 3'd1,
    S_READ       = 3'd2,
    S_CHECK      = 3'd3,
    S_SCAN_READ  = 3'd4,
    S_SCAN_CHECK = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_lfsr;
  logic [9:0]  r_rx;
  logic [9:0]  r_ry;
  logic [9:0]  r_wx;
  logic [9:0]  r_wy;
  logic [9:0]  w_cand_x;
  logic [9:0]  w_cand_y;
  logic        w_cand_ok;
  logic        w_empty;
  logic        w_renable;
  logic        w_wenable;
  logic        w_busy;

  assign w_cand_x  = {4'd0, r_lfsr[5:0]};
  assign w_cand_y  = {5'd0, r_lfsr[13:9]};
  assign w_cand_ok = (w_cand_x <= X_LAST) && (w_cand_y <= Y_LAST);
  assign w_empty   = (bus.fruta_rdata == 2'b00);

`ifdef FRUTA_SCAN_FALLBACK_EN
  logic [7:0] r_tries;
  logic       r_full;
  logic       w_tries_out;
  logic       w_scan_last;

  // Compared against the incremented count: this rejection is the last one.
  assign w_tries_out = ((r_tries + 8'd1) == 8'(MAX_TRIES));
  assign w_scan_last = (r_rx == X_LAST) && (r_ry == Y_LAST);
  assign bus.fruta_full = r_full;
`else
  assign bus.fruta_full = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_renable   = 1'b0;
    w_wenable   = 1'b0;
    w_busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (bus.fruta_enable) w_state_nxt = S_DRAW;
      end
      S_DRAW: begin
        // Out-of-range candidates simply wait one LFSR step.
        if (w_cand_ok) w_state_nxt = S_READ;
      end
      S_READ: begin
        w_renable   = 1'b1;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_empty) begin
          w_state_nxt = S_DONE;
        end else begin
`ifdef FRUTA_SCAN_FALLBACK_EN
          w_state_nxt = w_tries_out ? S_SCAN_READ : S_DRAW;
`else
          w_state_nxt = S_DRAW;
`endif
        end
      end
`ifdef FRUTA_SCAN_FALLBACK_EN
      S_SCAN_READ: begin
        w_renable   = 1'b1;
        w_state_nxt = S_SCAN_CHECK;
      end
      S_SCAN_CHECK: begin
        w_state_nxt = (w_empty || w_scan_last) ? S_DONE : S_SCAN_READ;
      end
`endif
      S_DONE: begin
        // A request coinciding with the strobe is dropped on purpose.
        w_wenable   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: LFSR runs every cycle so request timing adds entropy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr  <= LFSR_SEED;
      r_rx    <= 10'd0;
      r_ry    <= 10'd0;
      r_wx    <= 10'd0;
      r_wy    <= 10'd0;
`ifdef FRUTA_SCAN_FALLBACK_EN
      r_tries <= 8'd0;
      r_full  <= 1'b0;
`endif
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
      case (r_state)
        S_IDLE: begin
`ifdef FRUTA_SCAN_FALLBACK_EN
          r_tries <= 8'd0;
`endif
        end
        S_DRAW: begin
          if (w_cand_ok) begin
            r_rx <= w_cand_x;
            r_ry <= w_cand_y;
          end
        end
        S_CHECK: begin
          if (w_empty) begin
            r_wx <= r_rx;
            r_wy <= r_ry;
`ifdef FRUTA_SCAN_FALLBACK_EN
            r_full <= 1'b0;
          end else begin
            r_tries <= r_tries + 8'd1;
            if (w_tries_out) begin
              r_rx <= 10'd0;
              r_ry <= 10'd0;
            end
`endif
          end
        end
`ifdef FRUTA_SCAN_FALLBACK_EN
        S_SCAN_CHECK: begin
          if (w_empty) begin
            r_wx   <= r_rx;
            r_wy   <= r_ry;
            r_full <= 1'b0;
          end else if (w_scan_last) begin
            // Full map: result coordinates keep their previous values.
            r_full <= 1'b1;
          end else if (r_rx == X_LAST) begin
            r_rx <= 10'd0;
            r_ry <= r_ry + 10'd1;
          end else begin
            r_rx <= r_rx + 10'd1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign bus.fruta_renable = w_renable;
  assign bus.fruta_wenable = w_wenable;
  assign bus.busy          = w_busy;
  assign bus.fruta_rx      = r_rx;
  assign bus.fruta_ry      = r_ry;
  assign bus.fruta_wx      = r_wx;
  assign bus.fruta_wy      = r_wy;
endmodule
`default_nettype wire

// File: tb/tb_fruta_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fruta_gen
// Purpose  : Self-checking bench for fruta_gen. A behavioural model predicts
//            each placement (cell and strobe cycle) from the LFSR sequence
//            and the map contents; a monitor compares every strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fruta_gen;
  localparam int          W     = 40;
  localparam int          H     = 30;
  localparam int          TRIES = 4;
  localparam logic [15:0] SEED  = 16'hACE1;

  typedef struct {
    int x;
    int y;
    bit full;
    int done;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fruta_if bus ();

  fruta_gen #(
    .MAPA_WIDTH (W),
    .MAPA_HEIGHT(H),
    .LFSR_SEED  (SEED),
    .MAX_TRIES  (TRIES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [1:0]  map [H][W];
  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  logic [15:0] m_lfsr = 16'h0;
  int          m_acc = -1;
  int          m_busy_until = -1;
  int          m_chk = -1;
  int          m_last_x = 0;
  int          m_last_y = 0;
  bit          first_rd_pending = 0;
  int          hold_x = 0;
  int          hold_y = 0;
  int          hold_full = 0;
  bit          prev_ren = 0;
  int          n_strobes = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [15:0] step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter and reference LFSR: reload on reset, step every cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_lfsr = SEED;
      cyc    = 0;
    end else begin
      m_lfsr = step(m_lfsr);
      cyc++;
    end
  end

  // Map memory: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.fruta_renable) begin
      if (int'(bus.fruta_rx) < W && int'(bus.fruta_ry) < H)
        bus.fruta_rdata <= map[int'(bus.fruta_ry)][int'(bus.fruta_rx)];
      else
        bus.fruta_rdata <= 2'b11;
    end
  end

  // Reference: request accepted in cycle cyc; LFSR value m_lfsr in that cycle.
  task automatic predict();
    exp_t        e;
    logic [15:0] l;
    int          t;
    int          cx;
    int          cy;
    bit          found;
`ifdef FRUTA_SCAN_FALLBACK_EN
    int          tries;
    tries = 0;
`endif
    l      = step(m_lfsr);
    t      = cyc + 1;
    found  = 0;
    m_chk  = -1;
    e.x    = m_last_x;
    e.y    = m_last_y;
    e.full = 0;
    e.done = -1;
    for (int g = 0; g < 200000 && !found; g++) begin
      cx = int'(l[5:0]);
      cy = int'(l[13:9]);
      if (cx >= W || cy >= H) begin
        t++;
        l = step(l);
      end else begin
        if (m_chk < 0) m_chk = t + 2;
        if (map[cy][cx] == 2'b00) begin
          e.x = cx; e.y = cy; e.done = t + 3; found = 1;
        end else begin
          t += 3;
          l = step(step(step(l)));
`ifdef FRUTA_SCAN_FALLBACK_EN
          tries++;
          if (tries == TRIES) begin
            for (int i = 0; i < W * H && e.done < 0; i++) begin
              if (map[i / W][i % W] == 2'b00) begin
                e.x = i % W; e.y = i / W; e.done = t + 2;
              end else begin
                t += 2;
              end
            end
            if (e.done < 0) begin
              e.full = 1;
              e.done = t;
            end
            found = 1;
          end
`endif
        end
      end
    end
    q.push_back(e);
    m_acc            = cyc;
    m_busy_until     = e.done;
    m_last_x         = e.x;
    m_last_y         = e.y;
    first_rd_pending = 1;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_ren = 0;
    end else begin
      check("busy", int'(bus.busy), int'(cyc > m_acc && cyc <= m_busy_until));
      if (bus.fruta_renable) begin
        check("rd_x_in_range", int'(int'(bus.fruta_rx) < W), 1);
        check("rd_y_in_range", int'(int'(bus.fruta_ry) < H), 1);
        check("renable_back_to_back", int'(prev_ren), 0);
        if (first_rd_pending) begin
          check("first_read_cycle", cyc, m_chk - 1);
          first_rd_pending = 0;
        end
      end
      if (bus.fruta_wenable) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
        end else begin
          mon_e = q.pop_front();
          n_strobes++;
          check("strobe_cycle", cyc, mon_e.done);
          check("wx", int'(bus.fruta_wx), mon_e.x);
          check("wy", int'(bus.fruta_wy), mon_e.y);
          check("full", int'(bus.fruta_full), int'(mon_e.full));
          hold_x    = mon_e.x;
          hold_y    = mon_e.y;
          hold_full = int'(mon_e.full);
        end
      end else begin
        check("wx_hold", int'(bus.fruta_wx), hold_x);
        check("wy_hold", int'(bus.fruta_wy), hold_y);
        check("full_hold", int'(bus.fruta_full), hold_full);
      end
      prev_ren = bus.fruta_renable;
    end
  end

  task automatic tick(input bit en);
    @(negedge clk);
    bus.fruta_enable = en;
    if (en && !reset && cyc > m_busy_until) predict();
  endtask

  task automatic request_at(input int n);
    while (cyc < n - 1) tick(0);
    tick(1);
    tick(0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q.size() != 0 || cyc <= m_busy_until) && k < 6000) begin
      tick(0);
      k++;
    end
    if (k >= 6000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
    end
    tick(0);
  endtask

  // mode 0: empty, 1: ~30% occupied, 2: all snake
  task automatic fill_map(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0:       map[y][x] = 2'b00;
          1:       map[y][x] = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
          default: map[y][x] = 2'b01;
        endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wenable"}, int'(bus.fruta_wenable), 0);
    check({tag, "_renable"}, int'(bus.fruta_renable), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_wx"}, int'(bus.fruta_wx), 0);
    check({tag, "_wy"}, int'(bus.fruta_wy), 0);
    check({tag, "_full"}, int'(bus.fruta_full), 0);
    check({tag, "_rx"}, int'(bus.fruta_rx), 0);
    check({tag, "_ry"}, int'(bus.fruta_ry), 0);
    check({tag, "_lfsr"}, int'(dut.r_lfsr), int'(SEED));
  endtask

  initial begin
    int acc;
    int guard;
    int s0;
    bus.fruta_enable = 1'b0;
    bus.fruta_rdata  = 2'b00;
    fill_map(0);

    // Power-up reset, then a request at cycle 10 on an empty map.
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;
    request_at(10);
    drain();

    // Extra pulses while busy and on the strobe cycle are dropped.
    tick(1); tick(0); tick(1); tick(0);
    while (cyc < m_busy_until - 1) tick(0);
    tick(1);
    tick(0);
    drain();
    tick(1); tick(0);
    drain();

    // Randomly occupied map with random request pulses.
    fill_map(1);
    repeat (600) tick($urandom_range(0, 3) == 0);
    drain();

    // Reset while in CHECK aborts with no strobe and reloads the seed.
    fill_map(1);
    tick(1);
    while (cyc < m_chk - 1) tick(0);
    @(negedge clk);
    reset            = 1'b1;
    bus.fruta_enable = 1'b0;
    q.delete();
    m_acc            = -1;
    m_busy_until     = -1;
    m_last_x         = 0;
    m_last_y         = 0;
    first_rd_pending = 0;
    hold_x           = 0;
    hold_y           = 0;
    hold_full        = 0;
    @(negedge clk);
    check_reset_outputs("mid");
    reset = 1'b0;
    fill_map(0);
    request_at(10);
    drain();

    // 1000 back-to-back requests on an empty map.
    s0    = n_strobes;
    acc   = 0;
    guard = 0;
    while (acc < 1000 && guard < 60000) begin
      tick(1);
      if (m_acc == cyc) acc++;
      guard++;
    end
    tick(0);
    drain();
    check("b2b_strobe_count", n_strobes - s0, 1000);

`ifdef FRUTA_SCAN_FALLBACK_EN
    // Single empty cell in the far corner, then a completely full map.
    fill_map(2);
    map[H-1][W-1] = 2'b00;
    tick(1); tick(0);
    drain();
    fill_map(2);
    tick(1); tick(0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
